// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the LCD sequencer
// Purpose: FSM state enum, init ROM byte constants and ROM length.
// Ports: none (package).
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP   = 3'd0,
    ST_INIT_LOAD = 3'd1,
    ST_IDLE      = 3'd2,
    ST_SETUP     = 3'd3,
    ST_PULSE     = 3'd4,
    ST_HOLD      = 3'd5,
    ST_FINISH    = 3'd6
  } state_e;

  // Function set 8-bit/2-line, display on, clear, entry mode increment.
  localparam logic [7:0]  INIT_BYTE_0  = 8'h38;
  localparam logic [7:0]  INIT_BYTE_1  = 8'h0C;
  localparam logic [7:0]  INIT_BYTE_2  = 8'h01;
  localparam logic [7:0]  INIT_BYTE_3  = 8'h06;
  localparam int unsigned INIT_ROM_LEN = 4;

endpackage

// File: rtl/lcd_init_rom.sv
// rtl/lcd_init_rom.sv - combinational init command ROM
// Purpose: maps the init index to the LCD init command byte.
// Ports:
//   idx       in  2  init byte index
//   init_byte out 8  command byte for that index
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [1:0] idx,
  output logic [7:0] init_byte
);

  always_comb begin
    case (idx)
      2'd0:    init_byte = INIT_BYTE_0;
      2'd1:    init_byte = INIT_BYTE_1;
      2'd2:    init_byte = INIT_BYTE_2;
      default: init_byte = INIT_BYTE_3;
    endcase
  end

endmodule

// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - LCD byte write sequencer with power-up init sequence
// Purpose: waits POWERUP_CYCLES after reset, writes the 4-byte init sequence,
//   then serves single-byte user writes issued as a custom instruction.
// Build option: LCD_SEQUENCER_INIT_SEQ_EN enables the power-up wait and init
//   sequence; when undefined reset exits straight to idle and init_done is 1.
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous active-low reset
//   clk_en     in   1   clock enable; 0 freezes all state
//   start      in   1   request pulse
//   dataA      in   32  bit0 = rs of the user byte
//   dataB      in   32  bits[7:0] = user byte
//   done       out  1   one-cycle completion strobe
//   result     out  32  {23'b0, rs, byte} of the completed user write
//   lcd_rs     out  1   register select
//   lcd_rw     out  1   constant 0 (write only)
//   lcd_en     out  1   enable strobe
//   lcd_data   out  8   data bus
//   init_done  out  1   init sequence completed
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 2500000,
  parameter int unsigned PULSE_CYCLES   = 100000,
  parameter int unsigned HOLD_CYCLES    = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic        done,
  output logic [31:0] result,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic [7:0]  lcd_data,
  output logic        init_done
);

  localparam logic [31:0] POWERUP_LAST = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0] PULSE_LAST   = 32'(PULSE_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST    = 32'(HOLD_CYCLES - 1);

`ifdef LCD_SEQUENCER_INIT_SEQ_EN
  localparam state_e RESET_STATE = ST_POWERUP;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pend_v_q, pend_v_d;
  logic        pend_rs_q, pend_rs_d;
  logic [7:0]  pend_byte_q, pend_byte_d;
  logic        user_q, user_d;         // byte in flight came from start
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic        lcd_en_q, lcd_en_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic [7:0]  lcd_data_q, lcd_data_d;
  logic        busy;
  logic        accept;
  logic        unused_bits;

`ifdef LCD_SEQUENCER_INIT_SEQ_EN
  logic [1:0]  idx_q, idx_d;
  logic        init_done_q, init_done_d;
  logic [7:0]  rom_byte;

  lcd_init_rom u_init_rom (
    .idx       (idx_q),
    .init_byte (rom_byte)
  );
`endif

  assign unused_bits = ^{dataA[31:1], dataB[31:8]};

  // One request at a time: pending or already being written blocks a new start.
  assign busy   = pend_v_q | (user_q & (state_q inside {ST_SETUP, ST_PULSE, ST_HOLD, ST_FINISH}));
  assign accept = start & ~busy;

  // State register (plus datapath registers).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RESET_STATE;
      cnt_q       <= '0;
      pend_v_q    <= 1'b0;
      pend_rs_q   <= 1'b0;
      pend_byte_q <= '0;
      user_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      lcd_en_q    <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= '0;
`ifdef LCD_SEQUENCER_INIT_SEQ_EN
      idx_q       <= '0;
      init_done_q <= 1'b0;
`endif
    end else if (clk_en) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_v_q    <= pend_v_d;
      pend_rs_q   <= pend_rs_d;
      pend_byte_q <= pend_byte_d;
      user_q      <= user_d;
      done_q      <= done_d;
      result_q    <= result_d;
      lcd_en_q    <= lcd_en_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_data_q  <= lcd_data_d;
`ifdef LCD_SEQUENCER_INIT_SEQ_EN
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
`endif
    end
  end

  // Next-state logic; the counter restarts from zero on every state change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_POWERUP:   if (cnt_q == POWERUP_LAST) state_d = ST_INIT_LOAD;
      ST_INIT_LOAD: state_d = ST_SETUP;
      ST_IDLE:      if (accept || pend_v_q) state_d = ST_SETUP;
      ST_SETUP:     state_d = ST_PULSE;
      ST_PULSE:     if (cnt_q == PULSE_LAST) state_d = ST_HOLD;
      ST_HOLD:      if (cnt_q == HOLD_LAST) state_d = ST_FINISH;
      ST_FINISH: begin
`ifdef LCD_SEQUENCER_INIT_SEQ_EN
        if (!user_q && (idx_q != 2'(INIT_ROM_LEN - 1))) state_d = ST_INIT_LOAD;
        else                                             state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default:      state_d = RESET_STATE;
    endcase
    cnt_d = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
  end

  // Output / datapath logic.
  always_comb begin
    pend_v_d    = pend_v_q;
    pend_rs_d   = pend_rs_q;
    pend_byte_d = pend_byte_q;
    user_d      = user_q;
    done_d      = 1'b0;
    result_d    = result_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;
`ifdef LCD_SEQUENCER_INIT_SEQ_EN
    idx_d       = idx_q;
    init_done_d = init_done_q;
`endif

    // Outside idle the request waits in the pending register.
    if (accept && state_q != ST_IDLE) begin
      pend_v_d    = 1'b1;
      pend_rs_d   = dataA[0];
      pend_byte_d = dataB[7:0];
    end

    case (state_q)
`ifdef LCD_SEQUENCER_INIT_SEQ_EN
      ST_INIT_LOAD: begin
        lcd_rs_d   = 1'b0;
        lcd_data_d = rom_byte;
        user_d     = 1'b0;
      end
`endif
      ST_IDLE: begin
        if (accept) begin
          lcd_rs_d   = dataA[0];
          lcd_data_d = dataB[7:0];
          user_d     = 1'b1;
        end else if (pend_v_q) begin
          lcd_rs_d   = pend_rs_q;
          lcd_data_d = pend_byte_q;
          pend_v_d   = 1'b0;
          user_d     = 1'b1;
        end
      end
      ST_FINISH: begin
        if (user_q) begin
          done_d   = 1'b1;
          result_d = {23'b0, lcd_rs_q, lcd_data_q};
        end
`ifdef LCD_SEQUENCER_INIT_SEQ_EN
        else if (idx_q == 2'(INIT_ROM_LEN - 1)) init_done_d = 1'b1;
        else                                     idx_d = idx_q + 2'd1;
`endif
      end
      default: ;
    endcase

    lcd_en_d = (state_d == ST_PULSE);
  end

  assign done     = done_q;
  assign result   = result_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = lcd_en_q;
  assign lcd_data = lcd_data_q;
`ifdef LCD_SEQUENCER_INIT_SEQ_EN
  assign init_done = init_done_q;
`else
  assign init_done = 1'b1;
`endif

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb/tb_lcd_sequencer.sv - self-checking bench for lcd_sequencer
module tb_lcd_sequencer;
  localparam int P = 4;
  localparam int H = 4;
  localparam int N = 10;

  logic        clk = 1'b0;
  logic        reset, clk_en, start;
  logic [31:0] dataA, dataB;
  logic        done;
  logic [31:0] result;
  logic        lcd_rs, lcd_rw, lcd_en;
  logic [7:0]  lcd_data;
  logic        init_done;

  always #5 clk = ~clk;

  lcd_sequencer #(.POWERUP_CYCLES(N), .PULSE_CYCLES(P), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .dataA(dataA), .dataB(dataB), .done(done), .result(result),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_data(lcd_data), .init_done(init_done)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a job timeline. A byte write is one job whose age counts
  // enabled cycles from its setup cycle: age 0 setup, 1..P enable high,
  // P+1..P+H hold, P+H+1 finish; it retires on the edge that takes it to P+H+2.
  logic [7:0] rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  bit         m_valid = 1'b0;
  int         m_pu_left, m_age, m_idx;
  bit         m_load, m_job, m_juser, m_jrs, m_init_done, m_pv, m_prs, m_done, m_rs;
  logic [7:0] m_jdata, m_pdata, m_data;
  logic [31:0] m_result;

  function automatic bit m_idle();
    return m_init_done && !m_job && !m_load && (m_pu_left == 0) && !m_pv;
  endfunction

  task automatic model_reset();
    m_valid = 1'b1;
`ifdef LCD_SEQUENCER_INIT_SEQ_EN
    m_pu_left = N; m_init_done = 1'b0;
`else
    m_pu_left = 0; m_init_done = 1'b1;
`endif
    m_load = 0; m_job = 0; m_age = 0; m_idx = 0; m_pv = 0; m_prs = 0; m_pdata = 0;
    m_done = 0; m_result = 0; m_rs = 0; m_data = 0; m_juser = 0; m_jrs = 0; m_jdata = 0;
  endtask

  task automatic begin_job(bit rs, logic [7:0] d, bit user);
    m_job = 1; m_age = 0; m_jrs = rs; m_jdata = d; m_juser = user;
    m_rs = rs; m_data = d;
  endtask

  task automatic model_step(bit st, bit rs, logic [7:0] d);
    bit idle_before, accept;
    idle_before = m_init_done && !m_job && !m_load && (m_pu_left == 0);
    accept = st && !(m_pv || (m_job && m_juser));
    m_done = 0;
    if (m_pu_left > 0) begin
      m_pu_left--;
      if (m_pu_left == 0) m_load = 1;
    end else if (m_load) begin
      m_load = 0;
      begin_job(1'b0, rom[m_idx], 1'b0);
    end else if (m_job) begin
      m_age++;
      if (m_age == P + H + 2) begin
        m_job = 0;
        if (m_juser) begin
          m_done = 1; m_result = {23'b0, m_jrs, m_jdata};
        end else if (m_idx < 3) begin
          m_idx++; m_load = 1;
        end else m_init_done = 1;
      end
    end else if (idle_before) begin
      if (accept) begin
        begin_job(rs, d, 1'b1);
        accept = 0;
      end else if (m_pv) begin
        begin_job(m_prs, m_pdata, 1'b1);
        m_pv = 0;
      end
    end
    if (accept) begin
      m_pv = 1; m_prs = rs; m_pdata = d;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset === 1'b0) model_reset();
    else if (clk_en === 1'b1 && m_valid) model_step(start, dataA[0], dataB[7:0]);
  end

  // Compare process plus done / enable-pulse monitors.
  int         done_cnt = 0, done_cyc = 0;
  bit         done_prev = 0, en_prev = 0;
  int         run_len = 0;
  logic [7:0] run_data = 0;
  bit         run_rs = 0;
  logic [7:0] pl_data[$];
  bit         pl_rs[$];
  int         pl_len[$];

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("lcd_en",    32'(lcd_en),    32'(m_job && m_age >= 1 && m_age <= P));
      chk("lcd_rs",    32'(lcd_rs),    32'(m_rs));
      chk("lcd_data",  32'(lcd_data),  32'(m_data));
      chk("lcd_rw",    32'(lcd_rw),    32'd0);
      chk("init_done", 32'(init_done), 32'(m_init_done));
      chk("done",      32'(done),      32'(m_done));
      chk("result",    result,         m_result);
      if (done === 1'b1 && !done_prev) begin
        done_cnt++; done_cyc = cyc;
      end
      done_prev = (done === 1'b1);
      if (lcd_en === 1'b1) begin
        if (!en_prev) begin
          run_len = 0; run_data = lcd_data; run_rs = lcd_rs;
        end
        run_len++;
      end else if (en_prev) begin
        pl_data.push_back(run_data); pl_rs.push_back(run_rs); pl_len.push_back(run_len);
      end
      en_prev = (lcd_en === 1'b1);
    end
  end

  int t_start = 0, done_base = 0;

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic clear_log();
    pl_data.delete(); pl_rs.delete(); pl_len.delete();
  endtask

  task automatic drive_start(bit rs, logic [7:0] b);
    dataA = $urandom; dataA[0] = rs;
    dataB = $urandom; dataB[7:0] = b;
    start = 1'b1; t_start = cyc; done_base = done_cnt;
    tick(1);
    start = 1'b0; dataA = $urandom; dataB = $urandom;
  endtask

  task automatic wait_done(int max);
    for (int i = 0; i < max; i++) begin
      if (done_cnt > done_base) break;
      tick(1);
    end
    chk("done_seen", 32'(done_cnt - done_base), 32'd1);
  endtask

  task automatic wait_idle(int max);
    for (int i = 0; i < max; i++) begin
      if (m_idle() && done !== 1'b1) break;
      tick(1);
    end
    chk("idle_reached", 32'(m_idle()), 32'd1);
  endtask

  task automatic wait_en(int max);
    for (int i = 0; i < max; i++) begin
      if (lcd_en === 1'b1) break;
      tick(1);
    end
    chk("en_seen", 32'(lcd_en), 32'd1);
  endtask

  initial begin
    logic [7:0] exp_init [5];
    int c0;
    exp_init = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h55};
    reset = 1'b0; clk_en = 1'b1; start = 1'b0; dataA = '0; dataB = '0;
    tick(2);
    chk("rst_lcd_en", 32'(lcd_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_lcd_data", 32'(lcd_data), 32'd0);
    chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
`ifdef LCD_SEQUENCER_INIT_SEQ_EN
    chk("rst_init_done", 32'(init_done), 32'd0);
`else
    chk("rst_init_done", 32'(init_done), 32'd1);
`endif
    reset = 1'b1;
    clear_log();

    // Request during the power-up wait: served only after the init bytes.
    tick(2);
    drive_start(1'b0, 8'h55);
    wait_done(300);
    chk("early_result", result, 32'h0000_0055);
`ifdef LCD_SEQUENCER_INIT_SEQ_EN
    chk("early_pulses", 32'(pl_data.size()), 32'd5);
    for (int i = 0; i < pl_data.size() && i < 5; i++) begin
      chk("early_data", 32'(pl_data[i]), 32'(exp_init[i]));
      chk("early_rs", 32'(pl_rs[i]), 32'd0);
      chk("early_len", 32'(pl_len[i]), 32'(P));
    end
`else
    chk("early_pulses", 32'(pl_data.size()), 32'd1);
`endif
    tick(3);
    chk("early_one_done", 32'(done_cnt), 32'd1);

    // Plain user write from idle.
    wait_idle(100); clear_log();
    drive_start(1'b1, 8'h41);
    wait_done(50);
    chk("lat_user", 32'(done_cyc - t_start), 32'd11);
    chk("res_user", result, 32'h0000_0141);
    tick(2);
    chk("user_pulses", 32'(pl_data.size()), 32'd1);
    if (pl_data.size() > 0) begin
      chk("user_data", 32'(pl_data[0]), 32'h41);
      chk("user_rs", 32'(pl_rs[0]), 32'd1);
      chk("user_len", 32'(pl_len[0]), 32'(P));
    end

    // Second start during the pulse is ignored.
    wait_idle(100);
    c0 = done_cnt;
    drive_start(1'b0, 8'h22);
    wait_en(10);
    drive_start(1'b1, 8'h33);
    tick(30);
    chk("dup_done_cnt", 32'(done_cnt - c0), 32'd1);
    chk("dup_result", result, 32'h0000_0022);

    // Clock enable low for 5 cycles mid-pulse stretches everything by 5.
    wait_idle(100); clear_log();
    drive_start(1'b0, 8'h5A);
    wait_en(10);
    tick(1);
    clk_en = 1'b0;
    tick(5);
    clk_en = 1'b1;
    wait_done(60);
    chk("lat_stall", 32'(done_cyc - t_start), 32'd16);
    tick(2);
    if (pl_len.size() > 0) chk("stall_len", 32'(pl_len[0]), 32'(P + 5));
    else chk("stall_pulses", 32'(pl_len.size()), 32'd1);

    // Randomised traffic with random clock-enable gaps.
    for (int i = 0; i < 600; i++) begin
      start  = ($urandom_range(0, 7) == 0);
      clk_en = ($urandom_range(0, 4) != 0);
      dataA  = $urandom;
      dataB  = $urandom;
      tick(1);
    end
    start = 1'b0; clk_en = 1'b1;
    wait_idle(200);

    // Reset in the middle of a user pulse.
    drive_start(1'b1, 8'h77);
    c0 = done_cnt;
    wait_en(10);
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("rst_mid_en", 32'(lcd_en), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    reset = 1'b1;
    clear_log();
    wait_idle(200);
    tick(5);
    chk("rst_mid_no_done", 32'(done_cnt - c0), 32'd0);
    chk("rst_mid_init_done", 32'(init_done), 32'd1);
`ifdef LCD_SEQUENCER_INIT_SEQ_EN
    chk("replay_pulses", 32'(pl_data.size()), 32'd4);
    if (pl_data.size() > 0) chk("replay_first", 32'(pl_data[0]), 32'h38);
`else
    chk("replay_pulses", 32'(pl_data.size()), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
